// File: rtl/toggle_merge_rx.sv
// Receiver for a two-phase dot/blank toggle pair: synchronises both event lines,
// enforces strict dot/blank alternation, and merges accepted events into one stream.
module toggle_merge_rx #(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             dot_in,
   input  logic             blank_in,
   input  logic             en,
   input  logic             clr_err,
   output logic             ack,
   output logic             evt,
   output logic             evt_is_dot,
   output logic [CNT_W-1:0] evt_cnt,
   output logic             err,
   output logic [1:0]       dbg_state_o
);

   typedef enum logic [1:0] {
      EXP_DOT   = 2'd0,
      EXP_BLANK = 2'd1,
      ERR       = 2'd2
   } state_t;

   state_t             state_q;
   logic [SYNC_STAGES-1:0] dot_sync_q;
   logic [SYNC_STAGES-1:0] blank_sync_q;
   logic               dot_ref_q;
   logic               blank_ref_q;
   logic               ack_q;
   logic               evt_q;
   logic               evt_is_dot_q;
   logic [CNT_W-1:0]   evt_cnt_q;
   logic               err_q;

   logic dot_lvl;
   logic blank_lvl;
   logic dot_pend;
   logic blank_pend;

   assign dot_lvl    = dot_sync_q[SYNC_STAGES-1];
   assign blank_lvl  = blank_sync_q[SYNC_STAGES-1];
   assign dot_pend   = dot_lvl != dot_ref_q;
   assign blank_pend = blank_lvl != blank_ref_q;

   // The raw inputs are sampled only here; everything downstream sees the last stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dot_sync_q   <= '0;
         blank_sync_q <= '0;
      end else begin
         dot_sync_q   <= {dot_sync_q[SYNC_STAGES-2:0], dot_in};
         blank_sync_q <= {blank_sync_q[SYNC_STAGES-2:0], blank_in};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= EXP_DOT;
         dot_ref_q    <= 1'b0;
         blank_ref_q  <= 1'b0;
         ack_q        <= 1'b0;
         evt_q        <= 1'b0;
         evt_is_dot_q <= 1'b0;
         evt_cnt_q    <= '0;
         err_q        <= 1'b0;
      end else begin
         evt_q <= 1'b0;
         // Any enabled cycle consumes whatever is pending, accepted or not.
         if (en) begin
            dot_ref_q   <= dot_lvl;
            blank_ref_q <= blank_lvl;
         end
         case (state_q)
            EXP_DOT: begin
               if (en && (dot_pend || blank_pend)) begin
                  if (dot_pend && !blank_pend) begin
                     evt_q        <= 1'b1;
                     evt_is_dot_q <= 1'b1;
                     ack_q        <= ~ack_q;
                     evt_cnt_q    <= evt_cnt_q + CNT_W'(1);
                     state_q      <= EXP_BLANK;
                  end else begin
                     err_q   <= 1'b1;
                     state_q <= ERR;
                  end
               end
            end
            EXP_BLANK: begin
               if (en && (dot_pend || blank_pend)) begin
                  if (blank_pend && !dot_pend) begin
                     evt_q        <= 1'b1;
                     evt_is_dot_q <= 1'b0;
                     ack_q        <= ~ack_q;
                     evt_cnt_q    <= evt_cnt_q + CNT_W'(1);
                     state_q      <= EXP_DOT;
                  end else begin
                     err_q   <= 1'b1;
                     state_q <= ERR;
                  end
               end
            end
            ERR: begin
               // Clearing resynchronises the references, dropping anything in flight.
               if (clr_err) begin
                  err_q       <= 1'b0;
                  state_q     <= EXP_DOT;
                  dot_ref_q   <= dot_lvl;
                  blank_ref_q <= blank_lvl;
               end
            end
            default: begin
               err_q   <= 1'b1;
               state_q <= ERR;
            end
         endcase
      end
   end

   assign ack         = ack_q;
   assign evt         = evt_q;
   assign evt_is_dot  = evt_is_dot_q;
   assign evt_cnt     = evt_cnt_q;
   assign err         = err_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_toggle_merge_rx.sv
// Bench for toggle_merge_rx: spec-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_toggle_merge_rx;

   localparam int SS = 2;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          dot_in = 1'b0;
   logic          blank_in = 1'b0;
   logic          en = 1'b1;
   logic          clr_err = 1'b0;
   logic          ack;
   logic          evt;
   logic          evt_is_dot;
   logic [CW-1:0] evt_cnt;
   logic          err;
   logic [1:0]    dbg_state;

   int errors = 0;
   int checks = 0;
   int evt_seen = 0;
   bit isdot_log[$];

   toggle_merge_rx #(.SYNC_STAGES(SS), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .dot_in(dot_in), .blank_in(blank_in), .en(en),
      .clr_err(clr_err), .ack(ack), .evt(evt), .evt_is_dot(evt_is_dot),
      .evt_cnt(evt_cnt), .err(err), .dbg_state_o(dbg_state)
   );

   always #5 clk = ~clk;

   // Reference model: the synchronised level of a line is simply the input value
   // seen SS rising edges ago; the protocol rules are then applied per edge.
   bit            d_hist[$];
   bit            b_hist[$];
   bit            m_ref_d = 0, m_ref_b = 0, m_want_dot = 1;
   bit            m_err = 0, m_evt = 0, m_isdot = 0, m_ack = 0;
   logic [CW-1:0] m_cnt = '0;

   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            d_hist.delete();
            b_hist.delete();
            m_ref_d = 0; m_ref_b = 0; m_want_dot = 1;
            m_err = 0; m_evt = 0; m_isdot = 0; m_ack = 0; m_cnt = '0;
         end else begin
            bit ds, bs, dp, bp;
            ds = (d_hist.size() >= SS) ? d_hist[SS-1] : 1'b0;
            bs = (b_hist.size() >= SS) ? b_hist[SS-1] : 1'b0;
            d_hist.push_front(dot_in);
            b_hist.push_front(blank_in);
            if (d_hist.size() > SS) void'(d_hist.pop_back());
            if (b_hist.size() > SS) void'(b_hist.pop_back());
            dp = ds != m_ref_d;
            bp = bs != m_ref_b;
            m_evt = 0;
            if (m_err) begin
               if (clr_err) begin
                  m_err = 0; m_want_dot = 1; m_ref_d = ds; m_ref_b = bs;
               end else if (en) begin
                  m_ref_d = ds; m_ref_b = bs;
               end
            end else if (en) begin
               if (dp || bp) begin
                  if ((m_want_dot && dp && !bp) || (!m_want_dot && bp && !dp)) begin
                     m_evt = 1; m_isdot = m_want_dot; m_ack = !m_ack;
                     m_cnt = m_cnt + 1'b1; m_want_dot = !m_want_dot;
                  end else begin
                     m_err = 1;
                  end
               end
               m_ref_d = ds; m_ref_b = bs;
            end
         end
      end
   end

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         chk("model_evt", evt, m_evt);
         chk("model_evt_is_dot", evt_is_dot, m_isdot);
         chk("model_ack", ack, m_ack);
         chk("model_evt_cnt", evt_cnt, m_cnt);
         chk("model_err", err, m_err);
         if (evt === 1'b1) begin
            evt_seen++;
            isdot_log.push_back(evt_is_dot);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1; dot_in = 1'b0; blank_in = 1'b0; en = 1'b1; clr_err = 1'b0;
      step(2);
      rst = 1'b0;
      step(1);
      isdot_log.delete();
      evt_seen = 0;
   endtask

   initial begin
      // Reset values and first-event latency.
      do_reset();
      chk("rst_evt", evt, 0);
      chk("rst_ack", ack, 0);
      chk("rst_cnt", evt_cnt, 0);
      chk("rst_err", err, 0);
      dot_in = 1'b1;
      step(2);
      chk("lat_no_evt_early", evt, 0);
      step(1);
      chk("lat_evt_edge3", evt, 1);
      chk("lat_is_dot", evt_is_dot, 1);
      chk("lat_ack", ack, 1);
      chk("lat_cnt", evt_cnt, 1);

      // Alternating dot/blank, four cycles apart.
      do_reset();
      dot_in = 1'b1;   step(4);
      blank_in = 1'b1; step(4);
      dot_in = 1'b0;   step(4);
      blank_in = 1'b0; step(4);
      chk("alt_pulses", evt_seen, 4);
      chk("alt_seq", (isdot_log.size() == 4) ?
          {isdot_log[0], isdot_log[1], isdot_log[2], isdot_log[3]} : 4'hf, 4'b1010);
      chk("alt_ack", ack, 0);
      chk("alt_cnt", evt_cnt, 4);
      chk("alt_err", err, 0);

      // Blank first is an ordering error; clear then accept a dot.
      do_reset();
      blank_in = 1'b1; step(4);
      chk("ooo_err", err, 1);
      chk("ooo_no_evt", evt_seen, 0);
      chk("ooo_ack", ack, 0);
      clr_err = 1'b1; step(1); clr_err = 1'b0;
      chk("clr_err", err, 0);
      dot_in = 1'b1; step(4);
      chk("clr_then_dot_cnt", evt_cnt, 1);
      chk("clr_then_dot_err", err, 0);

      // Clear coinciding with a freshly pending event discards that event.
      do_reset();
      blank_in = 1'b1; step(4);
      dot_in = 1'b1; step(2);
      clr_err = 1'b1; step(1); clr_err = 1'b0;
      chk("clr_win_err", err, 0);
      step(3);
      chk("clr_win_cnt", evt_cnt, 0);
      chk("clr_win_no_evt", evt_seen, 0);
      dot_in = 1'b0; step(4);
      chk("clr_win_next_dot", evt_cnt, 1);

      // Both lines change together.
      do_reset();
      dot_in = 1'b1; blank_in = 1'b1; step(4);
      chk("both_err", err, 1);
      chk("both_cnt", evt_cnt, 0);

      // Disabled consumption holds the event until enable returns.
      do_reset();
      en = 1'b0; dot_in = 1'b1; step(10);
      chk("en0_no_evt", evt_seen, 0);
      chk("en0_cnt", evt_cnt, 0);
      en = 1'b1; step(1);
      chk("en1_evt", evt, 1);
      chk("en1_cnt", evt_cnt, 1);
      step(1);
      chk("en1_single", evt_seen, 1);

      // 17 back-to-back alternating events wrap a 4-bit counter.
      do_reset();
      for (int i = 0; i < 17; i++) begin
         if (i % 2 == 0) dot_in = ~dot_in;
         else blank_in = ~blank_in;
         step(1);
      end
      step(4);
      chk("wrap_pulses", evt_seen, 17);
      chk("wrap_cnt", evt_cnt, 1);
      chk("wrap_ack", ack, 1);
      chk("wrap_is_dot", evt_is_dot, 1);
      chk("wrap_err", err, 0);

      // Reset mid-stream clears outputs immediately; dot is expected afterwards.
      blank_in = ~blank_in;
      step(2);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_outputs", {ack, evt, evt_is_dot, evt_cnt, err}, 0);
      dot_in = 1'b0; blank_in = 1'b0;
      step(2);
      rst = 1'b0;
      step(1);
      dot_in = 1'b1; step(4);
      chk("post_rst_dot_cnt", evt_cnt, 1);
      chk("post_rst_err", err, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
